// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu shared definitions: HLOp encodings, FSM states, helpers.
// Optional accumulate ops are enabled by the MDU_MADD_EN macro.
package hilo_mdu_pkg;

  localparam logic [3:0] HL_none  = 4'd0;
  localparam logic [3:0] HL_mult  = 4'd1;
  localparam logic [3:0] HL_multu = 4'd2;
  localparam logic [3:0] HL_div   = 4'd3;
  localparam logic [3:0] HL_divu  = 4'd4;
  localparam logic [3:0] HL_mfhi  = 4'd5;
  localparam logic [3:0] HL_mflo  = 4'd6;
  localparam logic [3:0] HL_mthi  = 4'd7;
  localparam logic [3:0] HL_mtlo  = 4'd8;
  localparam logic [3:0] HL_madd  = 4'd9;
  localparam logic [3:0] HL_maddu = 4'd10;
  localparam logic [3:0] HL_msub  = 4'd11;
  localparam logic [3:0] HL_msubu = 4'd12;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic int max_cyc(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational HI/LO result generator for mul/div/accumulate.
// Accumulate results are always computed; MDU_MADD_EN gating lives in hilo_mdu.
module mdu_arith
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [W2-1:0]    sprod;
  logic [W2-1:0]    uprod;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] squo;
  logic [WIDTH-1:0] srem;
  logic [WIDTH-1:0] uquo;
  logic [WIDTH-1:0] urem;
  logic             dz;
  logic             ovf;

  always_comb begin
    // low 2W bits of a sign-extended product equal the signed product
    sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc   = {hi, lo};
    dz    = (b == '0);
    ovf   = (a == MIN_NEG) && (b == {WIDTH{1'b1}});
    squo  = $unsigned($signed(a) / $signed(b));
    srem  = $unsigned($signed(a) % $signed(b));
    uquo  = a / b;
    urem  = a % b;
    next_hi = hi;
    next_lo = lo;
    case (op)
      HL_mult:  {next_hi, next_lo} = sprod;
      HL_multu: {next_hi, next_lo} = uprod;
      HL_div: begin
        if (dz) begin
          next_hi = a;
          next_lo = {WIDTH{1'b1}};
        end else if (ovf) begin
          next_hi = '0;
          next_lo = a;
        end else begin
          next_hi = srem;
          next_lo = squo;
        end
      end
      HL_divu: begin
        if (dz) begin
          next_hi = a;
          next_lo = {WIDTH{1'b1}};
        end else begin
          next_hi = urem;
          next_lo = uquo;
        end
      end
      HL_madd:  {next_hi, next_lo} = acc + sprod;
      HL_maddu: {next_hi, next_lo} = acc + uprod;
      HL_msub:  {next_hi, next_lo} = acc - sprod;
      HL_msubu: {next_hi, next_lo} = acc - uprod;
      default: ;
    endcase
  end

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO owner with multi-cycle mul/div and mthi/mtlo writes.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       HLOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HLOut
);

  localparam int CW = $clog2(max_cyc(MULT_CYCLES, DIV_CYCLES)) + 1;

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             is_mul;
  logic             is_div;

  always_comb begin
    is_mul = (HLOp == HL_mult) || (HLOp == HL_multu);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (HLOp == HL_madd) || (HLOp == HL_maddu)
          || (HLOp == HL_msub) || (HLOp == HL_msubu);
`else
    is_mul = is_mul || 1'b0;
`endif
    is_div = (HLOp == HL_div) || (HLOp == HL_divu);
  end

  mdu_arith #(
    .WIDTH(WIDTH)
  ) u_arith (
    .op      (HLOp),
    .a       (A),
    .b       (B),
    .hi      (HI),
    .lo      (LO),
    .next_hi (res_hi),
    .next_lo (res_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= MDU_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start && (is_mul || is_div)) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy    <= 1'b1;
            state   <= MDU_BUSY;
          end else if (start && HLOp == HL_mthi) begin
            HI <= A;
          end else if (start && HLOp == HL_mtlo) begin
            LO <= A;
          end
        end
        MDU_BUSY: begin
          // new starts are ignored here; the hazard unit stalls them in D
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            HI    <= pend_hi;
            LO    <= pend_lo;
            busy  <= 1'b0;
            state <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  always_comb begin
    HLOut = '0;
    if (HLOp == HL_mfhi) HLOut = HI;
    else if (HLOp == HL_mflo) HLOut = LO;
  end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
Parametrised multiply/divide unit owning the HI/LO register pair; sits in stage E beside the ALU and is driven by the decoder's HLOp field. Executes mult/multu/div/divu with configurable multi-cycle latency and mthi/mtlo writes. Returns mfhi/mflo data. Exposes busy so the hazard unit can stall HL-class instructions in D.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, cycles busy after an accepted mult/multu (>=1)
DIV_CYCLES, 10, cycles busy after an accepted div/divu (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset, clears all state
start  in  1  E-stage instruction valid (not a bubble)
HLOp  in  4  operation code, encodings from shared package
A  in  WIDTH  rs operand (forwarded)
B  in  WIDTH  rt operand (forwarded)
busy  out  1  registered; high while an operation is in flight
HI  out  WIDTH  current HI register
LO  out  WIDTH  current LO register
HLOut  out  WIDTH  combinational: HI when HLOp==HL_mfhi, LO when HL_mflo, else 0

Behaviour:
- Reset (async, reset==0): HI=0, LO=0, busy=0, counter=0, state IDLE. Reset mid-operation aborts it; no HI/LO write afterwards.
- States: IDLE, BUSY. Counter width $clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
- IDLE & start & HLOp in {mult,multu,div,divu}: latch the result into pending registers at that edge. Load counter with MULT_CYCLES or DIV_CYCLES. busy=1 from the next cycle. Go to BUSY.
- BUSY: counter decrements each edge. On the edge where counter==1: HI/LO take the pending result, busy->0, state->IDLE. An op accepted at edge t therefore updates HI/LO and drops busy at edge t+N (N = op's cycle count). busy is high for exactly N cycles.
- mult: {HI,LO} = signed A*B (2*WIDTH). multu: unsigned product.
- div: LO = signed A/B, truncating toward zero; HI = remainder, with the sign of A. divu: unsigned quotient/remainder.
- Divide by zero (B==0): LO = all ones, HI = A. Timing is unchanged (DIV_CYCLES).
- Signed overflow (A = most-negative, B = -1): LO = A, HI = 0.
- IDLE & start & HL_mthi: HI=A at the next edge. HL_mtlo: LO=A at the next edge. These are single-cycle; busy stays 0.
- start==0 or HLOp==HL_none: no state change.
- Any start while BUSY: ignored. No state change, and the counter is not reloaded. The hazard unit must stall md/mf/mt in D whenever busy | (start & md-class HLOp). The bench checks that an illegal start is ignored.
- HLOut reads the committed HI/LO only; pending results are invisible until commit.
- Undefined HLOp codes are treated as HL_none.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: adds HL_madd, HL_maddu, HL_msub, HL_msubu (codes 9-12). {HI,LO} ± product (signed or unsigned per op), modulo 2^(2*WIDTH). Latency MULT_CYCLES. The accumulate base is the {HI,LO} value captured at accept.
- Not defined: codes 9-12 are treated as HL_none, with no state change.

Decomposition:
- Shared package/include (alongside the existing constant file): HL_none=0, HL_mult=1, HL_multu=2, HL_div=3, HL_divu=4, HL_mfhi=5, HL_mflo=6, HL_mthi=7, HL_mtlo=8, HL_madd=9, HL_maddu=10, HL_msub=11, HL_msubu=12. State encodings MDU_IDLE/MDU_BUSY.
- One natural sub-module: mdu_arith, a combinational result generator (op, A, B, HI, LO -> next_hi, next_lo, including the divide-by-zero and overflow rules). hilo_mdu keeps the FSM, counter and registers.

Test Plan:
- mult A=0xFFFFFFFF, B=2 at edge t -> busy high for cycles t+1..t+5; at t+5 HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; busy drops after exactly DIV_CYCLES.
- mthi A=0x1234 then mflo/mfhi with start=1 -> HI=0x1234 next edge, busy stays 0, HLOut=0x1234 on mfhi.
- mult in flight, second mult/mtlo asserted at cycle 2 -> ignored, HI/LO reflect only the first op; reset asserted at cycle 3 -> HI=LO=0, busy=0 immediately, no later commit.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0 after 5 cycles; without MDU_MADD_EN, same stimulus -> no change, busy stays 0.
